// File: rtl/panel_scanner.sv
// Front-panel matrix scanner: multiplexes an LED image over LED rows, scans and debounces a switch matrix.
// Optional PANEL_DIM_EN adds a 4-bit brightness input that shortens the lit part of each LED dwell.
module panel_scanner #(
    parameter int COLS     = 12,
    parameter int LED_ROWS = 8,
    parameter int SW_ROWS  = 3,
    parameter int DWELL    = 1000,
    parameter int BLANK    = 8,
    parameter int SETTLE   = 16,
    parameter int DEBOUNCE = 4
) (
    input  logic                      clk,
    input  logic                      rst,
`ifdef PANEL_DIM_EN
    input  logic [3:0]                brightness,
`endif
    input  logic [LED_ROWS*COLS-1:0]  led_data,
    output logic [LED_ROWS-1:0]       led_row,
    output logic [SW_ROWS-1:0]        sw_row,
    output logic [COLS-1:0]           col_out,
    output logic                      col_oe,
    input  logic [COLS-1:0]           col_in,
    output logic [SW_ROWS*COLS-1:0]   sw_state,
    output logic                      sw_valid,
    output logic                      frame_done
);

    localparam int TMAX = (DWELL > BLANK) ? ((DWELL > SETTLE) ? DWELL : SETTLE)
                                          : ((BLANK > SETTLE) ? BLANK : SETTLE);
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int RMAX = (LED_ROWS > SW_ROWS) ? LED_ROWS : SW_ROWS;
    localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;
    localparam int CW   = $clog2(DEBOUNCE + 1);
    localparam int IMG  = SW_ROWS * COLS;

    typedef enum logic [1:0] {
        ST_BLANK,
        ST_LED,
        ST_SW_SETTLE,
        ST_SW_SAMPLE
    } state_t;

    state_t          state, state_n;
    logic [TW-1:0]   timer, timer_n;
    logic [RW-1:0]   row, row_n;
    logic [COLS-1:0] col_latch;
    logic [COLS-1:0] sync1, sync2;
    logic [IMG-1:0]  raw, raw_n, prev_raw;
    logic [CW-1:0]   stable_cnt, cnt_n;
    logic            latch_en, sample_en, frame_end;
    logic            lit;

`ifdef PANEL_DIM_EN
    logic [31:0] dim_limit;
    assign dim_limit = (32'(brightness) * 32'(DWELL)) / 32'd16;
    assign lit       = 32'(timer) < dim_limit;
`else
    assign lit = 1'b1;
`endif

    always_comb begin
        state_n   = state;
        timer_n   = timer + TW'(1);
        row_n     = row;
        latch_en  = 1'b0;
        sample_en = 1'b0;
        frame_end = 1'b0;
        unique case (state)
            ST_BLANK: begin
                if (timer == TW'(BLANK - 1)) begin
                    state_n  = ST_LED;
                    timer_n  = '0;
                    latch_en = 1'b1;
                end
            end
            ST_LED: begin
                if (timer == TW'(DWELL - 1)) begin
                    timer_n = '0;
                    if (row == RW'(LED_ROWS - 1)) begin
                        state_n = ST_SW_SETTLE;
                        row_n   = '0;
                    end else begin
                        state_n = ST_BLANK;
                        row_n   = row + RW'(1);
                    end
                end
            end
            ST_SW_SETTLE: begin
                if (timer == TW'(SETTLE - 1)) begin
                    state_n = ST_SW_SAMPLE;
                    timer_n = '0;
                end
            end
            ST_SW_SAMPLE: begin
                sample_en = 1'b1;
                timer_n   = '0;
                if (row == RW'(SW_ROWS - 1)) begin
                    frame_end = 1'b1;
                    state_n   = ST_BLANK;
                    row_n     = '0;
                end else begin
                    state_n = ST_SW_SETTLE;
                    row_n   = row + RW'(1);
                end
            end
            default: state_n = ST_BLANK;
        endcase
    end

    // Row drive is decoded straight from the state so reset forces every line idle at once
    always_comb begin
        led_row = '0;
        sw_row  = '1;
        col_out = '1;
        col_oe  = 1'b0;
        if (state == ST_LED && lit) begin
            led_row = LED_ROWS'(1) << row;
            col_oe  = 1'b1;
            col_out = ~col_latch;
        end else if (state == ST_SW_SETTLE || state == ST_SW_SAMPLE) begin
            sw_row = ~(SW_ROWS'(1) << row);
        end
    end

    // The frame image includes the sample being taken this cycle, so debounce sees the whole frame
    always_comb begin
        raw_n = raw;
        raw_n[int'(row)*COLS +: COLS] = ~sync2;
        if (raw_n == prev_raw)
            cnt_n = (stable_cnt == CW'(DEBOUNCE)) ? stable_cnt : stable_cnt + CW'(1);
        else
            cnt_n = CW'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_BLANK;
            timer      <= '0;
            row        <= '0;
            col_latch  <= '0;
            sync1      <= '1;
            sync2      <= '1;
            raw        <= '0;
            prev_raw   <= '0;
            stable_cnt <= '0;
            sw_state   <= '0;
            sw_valid   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            timer      <= timer_n;
            row        <= row_n;
            sync1      <= col_in;
            sync2      <= sync1;
            sw_valid   <= 1'b0;
            frame_done <= frame_end;
            if (latch_en)
                col_latch <= led_data[int'(row)*COLS +: COLS];
            if (sample_en)
                raw <= raw_n;
            if (frame_end) begin
                prev_raw   <= raw_n;
                stable_cnt <= cnt_n;
                if (cnt_n == CW'(DEBOUNCE) && raw_n != sw_state) begin
                    sw_state <= raw_n;
                    sw_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_panel_scanner.sv
// Scoreboard bench for panel_scanner: a frame-level debounce model feeds a queue checked on frame_done.
// Build with PANEL_DIM_EN defined to exercise the brightness input.
module tb_panel_scanner;

    localparam int COLS      = 4;
    localparam int LED_ROWS  = 2;
    localparam int SW_ROWS   = 2;
    localparam int DWELL     = 4;
    localparam int BLANK     = 2;
    localparam int SETTLE    = 3;
    localparam int DEBOUNCE  = 2;
    localparam int SLOT      = BLANK + DWELL;
    localparam int LED_PHASE = LED_ROWS * SLOT;
    localparam int FRAME     = LED_PHASE + SW_ROWS * (SETTLE + 1);
    localparam int IMG       = SW_ROWS * COLS;

    typedef struct {
        logic           valid;
        logic [IMG-1:0] state;
    } exp_t;

    logic                     clk = 1'b0;
    logic                     rst = 1'b0;
    logic [LED_ROWS*COLS-1:0] led_data = '0;
    logic [IMG-1:0]           pressed = '0;
    logic [COLS-1:0]          col_in;
    logic [LED_ROWS-1:0]      led_row;
    logic [SW_ROWS-1:0]       sw_row;
    logic [COLS-1:0]          col_out;
    logic                     col_oe;
    logic [IMG-1:0]           sw_state;
    logic                     sw_valid;
    logic                     frame_done;
`ifdef PANEL_DIM_EN
    logic [3:0]               brightness = 4'd8;
`endif

    exp_t           sb[$];
    logic [IMG-1:0] hist[$];
    logic [IMG-1:0] model_state;
    int             checks = 0;
    int             fails  = 0;
    int             pos    = 0;

    panel_scanner #(
        .COLS(COLS), .LED_ROWS(LED_ROWS), .SW_ROWS(SW_ROWS), .DWELL(DWELL),
        .BLANK(BLANK), .SETTLE(SETTLE), .DEBOUNCE(DEBOUNCE)
    ) dut (
        .clk(clk),
        .rst(rst),
`ifdef PANEL_DIM_EN
        .brightness(brightness),
`endif
        .led_data(led_data),
        .led_row(led_row),
        .sw_row(sw_row),
        .col_out(col_out),
        .col_oe(col_oe),
        .col_in(col_in),
        .sw_state(sw_state),
        .sw_valid(sw_valid),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Pulled-up columns, pulled low through any closed switch on a driven row
    always_comb begin
        col_in = '1;
        for (int s = 0; s < SW_ROWS; s++)
            for (int c = 0; c < COLS; c++)
                if (!sw_row[s] && pressed[s*COLS + c])
                    col_in[c] = 1'b0;
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s at t=%0t pos=%0d: got %0h expected %0h", name, $time, pos, act, exp);
        end
    endtask

    function automatic bit is_lit(input int o);
`ifdef PANEL_DIM_EN
        return o < (int'(brightness) * DWELL) / 16;
`else
        return o >= 0;
`endif
    endfunction

    task automatic reset_model();
        hist.delete();
        sb.delete();
        model_state = '0;
    endtask

    // A new image is accepted once the last DEBOUNCE frames since reset all read the same
    task automatic model_frame(input logic [IMG-1:0] img);
        exp_t e;
        bit   stable;
        hist.push_back(img);
        e.valid = 1'b0;
        stable  = hist.size() >= DEBOUNCE;
        if (stable)
            for (int k = 1; k <= DEBOUNCE; k++)
                if (hist[hist.size() - k] != img) stable = 0;
        if (stable && img != model_state) begin
            model_state = img;
            e.valid     = 1'b1;
        end
        e.state = model_state;
        sb.push_back(e);
    endtask

    task automatic apply_stimulus(input logic [IMG-1:0] img, input logic [LED_ROWS*COLS-1:0] leds);
        pressed  = img;
        led_data = leds;
        model_frame(img);
        repeat (FRAME) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_led_row"}, 32'(led_row), 32'(0));
        check_output({tag, "_sw_row"}, 32'(sw_row), 32'({SW_ROWS{1'b1}}));
        check_output({tag, "_col_out"}, 32'(col_out), 32'({COLS{1'b1}}));
        check_output({tag, "_col_oe"}, 32'(col_oe), 32'(0));
        check_output({tag, "_sw_state"}, 32'(sw_state), 32'(0));
        check_output({tag, "_sw_valid"}, 32'(sw_valid), 32'(0));
        check_output({tag, "_frame_done"}, 32'(frame_done), 32'(0));
    endtask

    // Cycle-position model of the scan pattern plus scoreboard pop on every frame_done
    always @(negedge clk) begin
        int                  p, r, o, s;
        logic [LED_ROWS-1:0] e_led;
        logic [SW_ROWS-1:0]  e_sw;
        logic [COLS-1:0]     e_col;
        logic                e_oe;
        exp_t                e;
        if (!rst) begin
            pos = 0;
        end else begin
            p     = pos % FRAME;
            e_led = '0;
            e_sw  = '1;
            e_col = '1;
            e_oe  = 1'b0;
            if (p < LED_PHASE) begin
                r = p / SLOT;
                o = (p % SLOT) - BLANK;
                if (o >= 0 && is_lit(o)) begin
                    e_led = LED_ROWS'(1) << r;
                    e_oe  = 1'b1;
                    e_col = ~led_data[r*COLS +: COLS];
                end
            end else begin
                s    = (p - LED_PHASE) / (SETTLE + 1);
                e_sw = ~(SW_ROWS'(1) << s);
            end
            check_output("led_row", 32'(led_row), 32'(e_led));
            check_output("sw_row", 32'(sw_row), 32'(e_sw));
            check_output("col_out", 32'(col_out), 32'(e_col));
            check_output("col_oe", 32'(col_oe), 32'(e_oe));
            check_output("frame_done", 32'(frame_done), 32'(pos > 0 && p == 0));
            if (frame_done) begin
                if (sb.size() == 0) begin
                    checks++;
                    fails++;
                    $display("[TB] FAIL sb_underflow at t=%0t: frame_done with no expected frame", $time);
                end else begin
                    e = sb.pop_front();
                    check_output("sw_valid", 32'(sw_valid), 32'(e.valid));
                    check_output("sw_state", 32'(sw_state), 32'(e.state));
                end
            end else begin
                check_output("sw_valid_idle", 32'(sw_valid), 32'(0));
            end
            pos++;
        end
    end

    initial begin
        logic [IMG-1:0] img;
        int             hold;
        reset_model();
        led_data = 8'hA5;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("por");
        rst = 1'b1;

        // Row-0 column-0 switch held: accepted after the second frame only
        repeat (3) apply_stimulus(8'h01, 8'hA5);

        // Abort during the first settle cycle of switch row 1
        repeat (LED_PHASE + SETTLE + 1) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        reset_model();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        // A bouncing switch never holds long enough to be accepted
        for (int i = 0; i < 6; i++)
            apply_stimulus((i % 2 == 0) ? 8'h10 : 8'h00, 8'($urandom));

        // Press then release: exactly one accepted change each
        repeat (3) apply_stimulus(8'h82, 8'h3C);
        repeat (3) apply_stimulus(8'h00, 8'hC3);

        for (int i = 0; i < 12; i++) begin
            img  = 8'($urandom);
            hold = $urandom_range(1, 3);
`ifdef PANEL_DIM_EN
            brightness = 4'($urandom);
`endif
            repeat (hold) apply_stimulus(img, 8'($urandom));
        end

        @(negedge clk);
        #1;
        check_output("sb_drained", 32'(sb.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/panel_scanner.md
Name: panel_scanner

Overview:
- Parametrised front-panel matrix scanner; successor to the fixed 8-LED-row / 3-switch-row / 12-column PYNQ panel driver.
- Time-multiplexes a flat LED image onto LED rows and scans switch rows over shared bidirectional columns.
- Debounces the switch matrix and presents a registered switch image to the console logic.
- Column tri-stating lives one level up; this block exposes split col_out/col_oe/col_in.

Parameters:
COLS, 12, shared column count
LED_ROWS, 8, LED rows scanned per frame
SW_ROWS, 3, switch rows scanned per frame
DWELL, 1000, clocks each LED row is lit
BLANK, 8, clocks of dead time before each LED row (all rows off, columns released)
SETTLE, 16, clocks a switch row is driven before sampling
DEBOUNCE, 4, consecutive identical raw frames required to accept a new switch image (>=1)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low
led_data  in  LED_ROWS*COLS  LED image; bits [r*COLS +: COLS] belong to row r, 1 = lit
led_row  out  LED_ROWS  one-hot LED row select, active-high
sw_row  out  SW_ROWS  one-cold switch row select, active-low
col_out  out  COLS  column drive value, active-low (0 = LED lit)
col_oe  out  1  column output enable
col_in  in  COLS  column readback, pulled up; 0 = switch closed
sw_state  out  SW_ROWS*COLS  debounced switch image, 1 = closed, row s at [s*COLS +: COLS]
sw_valid  out  1  one-cycle pulse when sw_state changes
frame_done  out  1  one-cycle pulse after the last switch row sample

Behaviour:
- Reset (rst=0, async): led_row=0, sw_row=all 1, col_out=all 1, col_oe=0, sw_state=0, sw_valid=0, frame_done=0, FSM=BLANK, row index=0, stable count=0, raw and previous-raw frames=0.
- FSM states: BLANK -> LED -> (next row BLANK | SW_SETTLE) ; SW_SETTLE -> SW_SAMPLE -> (next SW_SETTLE | BLANK row 0).
- BLANK: BLANK clocks, all outputs idle as reset; on exit, latch led_data row r into the column register.
- LED: DWELL clocks; led_row[r]=1, col_oe=1, col_out = ~latched row. led_data changes mid-row take effect at the next row.
- After row LED_ROWS-1 LED: SW_SETTLE for SETTLE clocks with sw_row[s]=0, col_oe=0, led_row=0; then SW_SAMPLE for 1 clock, raw[s] <= ~col_in (synchronised through 2 flops; SETTLE must be >=2).
- After SW_SAMPLE of row SW_ROWS-1: frame_done pulses on the next cycle. Frame length = LED_ROWS*(BLANK+DWELL) + SW_ROWS*(SETTLE+1) clocks.
- Debounce at frame end: if raw == previous raw, stable count increments, saturating at DEBOUNCE; otherwise the count resets to 1. previous raw <= raw.
- When the count reaches DEBOUNCE and raw != sw_state: sw_state <= raw and sw_valid pulses in the same cycle as frame_done.
- No update and no pulse if raw already equals sw_state.
- LED and switch phases never overlap: col_oe=0 whenever any sw_row bit is 0.
- Reset asserted mid-frame aborts the scan immediately; the scan restarts at BLANK row 0 and debounce history is cleared.

Optional Feature:
PANEL_DIM_EN
- Defined: adds input brightness [3:0]. In LED state the row is lit (led_row and col_oe asserted) only while the dwell counter is < brightness*DWELL/16. The remainder of the dwell is idle; frame length is unchanged. brightness=0 gives a fully dark panel.
- Undefined: no brightness port; full-dwell drive.

Test Plan:
Bench parameters: COLS=4, LED_ROWS=2, SW_ROWS=2, DWELL=4, BLANK=2, SETTLE=3, DEBOUNCE=2; frame = 20 clocks.
- Reset release, led_data=8'hA5 -> cycles 2-5: led_row=01, col_out=4'hA; cycles 8-11: led_row=10, col_out=4'h5; col_oe=0 in all blank cycles; frame_done at cycle 20, repeating every 20.
- col_in=4'hE held during sw_row=10 only, otherwise 4'hF -> sw_state=8'h01 with a single sw_valid after the 2nd frame, coinciding with frame_done; no further pulses.
- Toggle col_in every frame -> sw_state stays 0, sw_valid never pulses.
- Switch press then release, each held for 3 frames -> exactly two sw_valid pulses; final sw_state=0.
- Assert rst during the SW_SETTLE of row 1 -> all outputs at reset values asynchronously; after release, led_row=01 at cycle 2.
- PANEL_DIM_EN with brightness=8 -> led_row high for 2 of 4 dwell clocks per row; frame still 20 clocks.
